// File: rtl/proj_node_param_if.sv
// Start/ready handshake bundle for proj_node_param: strobe, select and channel bus in,
// ready, result and range-error flag out.
interface proj_node_param_if #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int SW = 2
);
  logic           ST;
  logic [SW-1:0]  SEL;
  logic [N*W-1:0] IN;
  logic           RD;
  logic [W-1:0]   RES;
  logic           ERR;

  modport master (output ST, SEL, IN, input RD, RES, ERR);
  modport slave  (input ST, SEL, IN, output RD, RES, ERR);
endinterface

// File: rtl/proj_node_param.sv
// Parametrised projection node: on a rising ST edge, captures IN[SEL] into RES and raises RD
// LAT cycles after the capture. Optional feature macro: PROJ_NODE_RANGE_CHECK_EN.
module proj_node_param #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int SW  = 2,
  parameter int LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  proj_node_param_if.slave  bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, CAPT, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic           st_q;
  logic           start;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   sel_word;

  // st_q is deliberately outside reset so an ST held across reset release is not a start
  always_ff @(posedge CLK) begin
    st_q <= bus.ST;
  end

  assign start = bus.ST & ~st_q;

  // Out-of-range selects fall through to the last channel
  always_comb begin
    sel_word = bus.IN[(N-1)*W +: W];
    for (int i = 0; i < N; i++) begin
      if (int'(bus.SEL) == i) begin
        sel_word = bus.IN[i*W +: W];
      end
    end
  end

`ifdef PROJ_NODE_RANGE_CHECK_EN
  logic err_q, err_d;
  logic sel_oor;

  assign sel_oor = (int'(bus.SEL) >= N);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef PROJ_NODE_RANGE_CHECK_EN
    err_d   = err_q;
    if (start) begin
      err_d = 1'b0;
    end
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (start) begin
          state_d = CAPT;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(LAT - 1);
`ifdef PROJ_NODE_RANGE_CHECK_EN
          if (sel_oor) begin
            res_d = '0;
            err_d = 1'b1;
          end else begin
            res_d = sel_word;
            err_d = 1'b0;
          end
`else
          res_d   = sel_word;
`endif
        end
      end
      WAIT: begin
        if (start) begin
          state_d = CAPT;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef PROJ_NODE_RANGE_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.RD  = (state_q == IDLE) || (state_q == DONE);
  assign bus.RES = res_q;

endmodule

// File: tb/tb_proj_node_param.sv
// Bench for proj_node_param: three parameterisations share CLK/RST/ST, checked against a
// timeline model plus a vector table and hand-written corner sequences.
module tb_proj_node_param;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  proj_node_param_if #(.W(16), .N(4), .SW(2)) b0 ();
  proj_node_param_if #(.W(32), .N(8), .SW(3)) b1 ();
  proj_node_param_if #(.W(16), .N(3), .SW(2)) b2 ();

  proj_node_param #(.W(16), .N(4), .SW(2), .LAT(1)) u0 (.CLK(CLK), .RST(RST), .bus(b0.slave));
  proj_node_param #(.W(32), .N(8), .SW(3), .LAT(4)) u1 (.CLK(CLK), .RST(RST), .bus(b1.slave));
  proj_node_param #(.W(16), .N(3), .SW(2), .LAT(2)) u2 (.CLK(CLK), .RST(RST), .bus(b2.slave));

  int          LATv[3] = '{1, 4, 2};
  int          Nv[3]   = '{4, 8, 3};

  logic        st;
  logic [2:0]  sel[3];
  logic [31:0] ch[3][8];

  // Timeline model: a start edge schedules a capture on the next edge and RD rise LAT later
  logic        m_prev;
  bit          m_busy[3];
  bit          m_pend[3];
  int          m_rise[3];
  logic [31:0] m_res[3];
  bit          m_err[3];
  int          cyc;

  int          n_checks;
  int          n_fail;

  typedef struct {
    bit          st;
    logic [2:0]  sel;
    bit          rd;
    logic [15:0] res;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    b0.ST  = st;
    b1.ST  = st;
    b2.ST  = st;
    b0.SEL = sel[0][1:0];
    b1.SEL = sel[1];
    b2.SEL = sel[2][1:0];
    for (int i = 0; i < 8; i++) begin
      if (i < 4) b0.IN[i*16 +: 16] = ch[0][i][15:0];
      b1.IN[i*32 +: 32] = ch[1][i];
      if (i < 3) b2.IN[i*16 +: 16] = ch[2][i][15:0];
    end
  endtask

  task automatic model_edge();
    bit start;
    start = st && !m_prev;
    for (int d = 0; d < 3; d++) begin
      if (RST) begin
        m_busy[d] = 0;
        m_pend[d] = 0;
        m_res[d]  = '0;
        m_err[d]  = 0;
      end else if (start) begin
        m_busy[d] = 1;
        m_pend[d] = 1;
        m_err[d]  = 0;
      end else if (m_pend[d]) begin
        m_pend[d] = 0;
        m_rise[d] = cyc + LATv[d];
        if (int'(sel[d]) >= Nv[d]) begin
`ifdef PROJ_NODE_RANGE_CHECK_EN
          m_res[d] = '0;
          m_err[d] = 1;
`else
          m_res[d] = ch[d][Nv[d]-1];
`endif
        end else begin
          m_res[d] = ch[d][sel[d]];
        end
      end else if (m_busy[d] && cyc == m_rise[d]) begin
        m_busy[d] = 0;
      end
    end
    m_prev = st;
    cyc++;
  endtask

  task automatic cmp_model();
    check("m0_rd",  32'(b0.RD),  32'(!m_busy[0]));
    check("m0_res", 32'(b0.RES), m_res[0]);
    check("m0_err", 32'(b0.ERR), 32'(m_err[0]));
    check("m1_rd",  32'(b1.RD),  32'(!m_busy[1]));
    check("m1_res", b1.RES,      m_res[1]);
    check("m1_err", 32'(b1.ERR), 32'(m_err[1]));
    check("m2_rd",  32'(b2.RD),  32'(!m_busy[2]));
    check("m2_res", 32'(b2.RES), m_res[2]);
    check("m2_err", 32'(b2.ERR), 32'(m_err[2]));
  endtask

  task automatic step();
    drive();
    @(posedge CLK);
    model_edge();
    #1;
    cmp_model();
  endtask

  initial begin
    int lowcnt;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_prev   = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 0; m_pend[d] = 0; m_rise[d] = 0; m_res[d] = '0; m_err[d] = 0;
      sel[d] = 3'd0;
      for (int i = 0; i < 8; i++) ch[d][i] = (d == 1) ? $urandom : ($urandom & 32'hFFFF);
    end
    ch[0][0] = 32'hAAAA; ch[0][1] = 32'hBBBB; ch[0][2] = 32'hCCCC; ch[0][3] = 32'hDDDD;

    tbl[0]  = '{1'b0, 3'd2, 1'b1, 16'h0000};
    tbl[1]  = '{1'b1, 3'd2, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 3'd2, 1'b0, 16'hCCCC};
    tbl[3]  = '{1'b0, 3'd2, 1'b1, 16'hCCCC};
    tbl[4]  = '{1'b1, 3'd1, 1'b0, 16'hCCCC};
    tbl[5]  = '{1'b1, 3'd1, 1'b0, 16'hBBBB};
    tbl[6]  = '{1'b1, 3'd1, 1'b1, 16'hBBBB};
    tbl[7]  = '{1'b0, 3'd3, 1'b1, 16'hBBBB};
    tbl[8]  = '{1'b1, 3'd3, 1'b0, 16'hBBBB};
    tbl[9]  = '{1'b0, 3'd3, 1'b0, 16'hDDDD};
    tbl[10] = '{1'b0, 3'd3, 1'b1, 16'hDDDD};

    // Reset held with ST high, then released with ST still high
    RST = 1'b1;
    st  = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    repeat (2) begin
      step();
      check("rst_rd0",  32'(b0.RD),  32'd1);
      check("rst_rd1",  32'(b1.RD),  32'd1);
      check("rst_res0", 32'(b0.RES), 32'd0);
      check("rst_err2", 32'(b2.ERR), 32'd0);
    end

    // Basic projection and held-ST vectors on the default instance
    for (int v = 0; v < 11; v++) begin
      st = tbl[v].st;
      for (int d = 0; d < 3; d++) sel[d] = tbl[v].sel;
      step();
      check($sformatf("tbl%0d_rd", v),  32'(b0.RD),  32'(tbl[v].rd));
      check($sformatf("tbl%0d_res", v), 32'(b0.RES), 32'(tbl[v].res));
    end
    st = 1'b0;
    repeat (6) step();

    // LAT=4, N=8, W=32: RD low for exactly 5 cycles
    ch[1][7] = 32'h12345678;
    sel[1]   = 3'd7;
    st = 1'b1;
    step();
    lowcnt = (b1.RD == 1'b0) ? 1 : 0;
    st = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) check("lat4_res", b1.RES, 32'h12345678);
      if (b1.RD == 1'b0) lowcnt++;
      else break;
    end
    check("lat4_lowcnt", 32'(lowcnt), 32'd5);
    repeat (2) step();

    // Restart during WAIT on the LAT=4 instance
    sel[1] = 3'd0;
    st = 1'b1;
    step();
    st = 1'b0;
    step();
    sel[1] = 3'd1;
    st = 1'b1;
    step();
    lowcnt = 0;
    st = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      lowcnt++;
      if (b1.RD == 1'b1) break;
    end
    check("restart_rise", 32'(lowcnt), 32'd5);
    check("restart_res",  b1.RES, ch[1][1]);
    repeat (2) step();

    // Out-of-range select on the N=3 instance, then an in-range start
    sel[2] = 3'd3;
    st = 1'b1;
    step();
    st = 1'b0;
    step();
`ifdef PROJ_NODE_RANGE_CHECK_EN
    check("oor_res", 32'(b2.RES), 32'd0);
    check("oor_err", 32'(b2.ERR), 32'd1);
`else
    check("oor_res", 32'(b2.RES), ch[2][2]);
    check("oor_err", 32'(b2.ERR), 32'd0);
`endif
    repeat (3) step();
    sel[2] = 3'd0;
    st = 1'b1;
    step();
    check("oor_errclr", 32'(b2.ERR), 32'd0);
    st = 1'b0;
    step();
    check("oor_next_res", 32'(b2.RES), ch[2][0]);
    repeat (3) step();

    // Reset two cycles after a start edge on the LAT=4 instance
    st = 1'b1;
    step();
    st = 1'b0;
    step();
    RST = 1'b1;
    step();
    check("rstw_rd",  32'(b1.RD),  32'd1);
    check("rstw_res", b1.RES,      32'd0);
    RST = 1'b0;
    repeat (6) begin
      step();
      check("rstw_idle", 32'(b1.RD), 32'd1);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      st     = ($urandom_range(0, 2) == 0);
      RST    = ($urandom_range(0, 60) == 0);
      sel[0] = 3'($urandom_range(0, 3));
      sel[1] = 3'($urandom_range(0, 7));
      sel[2] = 3'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
        ch[0][i] = $urandom & 32'hFFFF;
        ch[1][i] = $urandom;
        ch[2][i] = $urandom & 32'hFFFF;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
